// File: rtl/sbox_word_seq.sv
// Word-level S-box sequencer: feeds one byte per cycle through a single
// combined forward/inverse S-box core, with optional RotWord on capture.

// Combined AES S-box / inverse S-box: GF(2^8) reciprocal wrapped by the
// forward affine map (after) or the inverse affine map (before).
module sbox_core (
  input  logic [7:0] i_byte,
  input  logic       i_inv,
  output logic [7:0] o_byte
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 for a != 0, and 0 for a == 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] aff(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] iaff(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

  logic [7:0] w_pre, w_rcp;

  assign w_pre  = i_inv ? iaff(i_byte) : i_byte;
  assign w_rcp  = ginv(w_pre);
  assign o_byte = i_inv ? w_rcp : aff(w_rcp);
endmodule

module sbox_word_seq #(
  parameter int NBYTES = 4,
  parameter int PIPE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_word,
  input  logic                  in_inv,
  input  logic                  in_rot,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_word,
  output logic                  busy
);
  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SUB, S_FLUSH, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [W-1:0]  r_word, r_out, w_cap_word;
  logic          r_inv;
  logic [CW-1:0] r_cnt, w_widx;
  logic [7:0]    w_byte, w_core_in, w_core_out;
  logic          w_cap, w_last, w_wen;

  assign in_ready   = !rst && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
  assign w_cap      = in_valid && in_ready;
  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state == S_SUB) || (r_state == S_FLUSH);
  assign out_word   = r_out;
  assign w_last     = (r_cnt == LAST);
  assign w_byte     = r_word[8*r_cnt +: 8];
  assign w_cap_word = in_rot ? {in_word[W-9:0], in_word[W-1:W-8]} : in_word;

  generate
    if (PIPE == 1) begin : g_pipe
      logic [7:0]    r_pbyte;
      logic [CW-1:0] r_pidx;
      logic          r_pvld;

      // Stage the selected byte and its index; the core result lands a cycle later
      always_ff @(posedge clk) begin
        if (rst) begin
          r_pbyte <= '0;
          r_pidx  <= '0;
          r_pvld  <= 1'b0;
        end else begin
          r_pbyte <= w_byte;
          r_pidx  <= r_cnt;
          r_pvld  <= (r_state == S_SUB);
        end
      end

      assign w_core_in = r_pbyte;
      assign w_widx    = r_pidx;
      assign w_wen     = r_pvld;
    end else begin : g_nopipe
      assign w_core_in = w_byte;
      assign w_widx    = r_cnt;
      assign w_wen     = (r_state == S_SUB);
    end
  endgenerate

  sbox_core u_core (
    .i_byte (w_core_in),
    .i_inv  (r_inv),
    .o_byte (w_core_out)
  );

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_cap) w_next = S_SUB;
      S_SUB:   if (w_last) w_next = (PIPE == 1) ? S_FLUSH : S_DONE;
      S_FLUSH: w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = w_cap ? S_SUB : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, capture registers, byte counter and result assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_inv   <= 1'b0;
      r_cnt   <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_next;
      if (w_cap) begin
        r_word <= w_cap_word;
        r_inv  <= in_inv;
        r_cnt  <= '0;
      end else if (r_state == S_SUB) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_wen) r_out[8*w_widx +: 8] <= w_core_out;
    end
  end
endmodule

// File: tb/tb_sbox_word_seq.sv
// Directed bench for sbox_word_seq: a PIPE=0 and a PIPE=1 instance,
// expected words queued at capture and compared when results appear.
module tb_sbox_word_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_inv, in_rot, out_valid, out_ready, busy;
  logic [31:0] in_word, out_word;
  logic        p_in_valid, p_in_ready, p_in_inv, p_in_rot, p_out_valid, p_out_ready, p_busy;
  logic [31:0] p_in_word, p_out_word;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  sbox_word_seq #(.NBYTES(4), .PIPE(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .in_inv(in_inv), .in_rot(in_rot), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .busy(busy)
  );

  sbox_word_seq #(.NBYTES(4), .PIPE(1)) u_dut_p (
    .clk(clk), .rst(rst), .in_valid(p_in_valid), .in_ready(p_in_ready), .in_word(p_in_word),
    .in_inv(p_in_inv), .in_rot(p_in_rot), .out_valid(p_out_valid), .out_ready(p_out_ready),
    .out_word(p_out_word), .busy(p_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one word and hold it across a single capture edge
  task automatic drive_in(input logic [31:0] w, input logic inv, input logic rot, input string tag);
    @(negedge clk);
    in_word  = w;
    in_inv   = inv;
    in_rot   = rot;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count edges until out_valid, then compare with the scoreboard head
  task automatic wait_out(input int lat, input bit tog, input string tag);
    int n;
    logic [31:0] e;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (tog) begin
        in_inv = ~in_inv;
        in_rot = ~in_rot;
      end
    end while (!out_valid && n < 30);
    chk({tag, "_latency"}, n, lat);
    if (sb.size() != 0) e = sb.pop_front();
    else e = 32'hxxxxxxxx;
    chk({tag, "_word"}, out_word, e);
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic p_word(input logic [31:0] w, input logic inv, input logic rot,
                        input logic [31:0] exp, input string tag);
    int n;
    logic [31:0] e;
    @(negedge clk);
    p_in_word  = w;
    p_in_inv   = inv;
    p_in_rot   = rot;
    p_in_valid = 1'b1;
    chk({tag, "_in_ready"}, {31'd0, p_in_ready}, 32'd1);
    sb.push_back(exp);
    @(posedge clk);
    #1 p_in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!p_out_valid && n < 30);
    chk({tag, "_latency"}, n, 5);
    if (sb.size() != 0) e = sb.pop_front();
    else e = 32'hxxxxxxxx;
    chk({tag, "_word"}, p_out_word, e);
    p_out_ready = 1'b1;
    @(posedge clk);
    #1 p_out_ready = 1'b0;
    chk({tag, "_drained"}, {31'd0, p_out_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_word = '0; in_inv = 1'b0; in_rot = 1'b0; out_ready = 1'b0;
    p_in_valid = 1'b0; p_in_word = '0; p_in_inv = 1'b0; p_in_rot = 1'b0; p_out_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_word", out_word, 32'h0);
    chk("rst_p_out_word", p_out_word, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // PIPE=1: one extra cycle of latency
    p_word(32'h09CF4F3C, 1'b0, 1'b1, 32'h8A84EB01, "p_rot");
    p_word(32'h53FF0001, 1'b0, 1'b0, 32'hED16637C, "p_mix");
    p_word(32'h637C0000, 1'b1, 1'b0, 32'h00015252, "p_inv");

    // forward all-zero
    sb.push_back(32'h63636363);
    drive_in(32'h00000000, 1'b0, 1'b0, "fwd0");
    chk("fwd0_busy", {31'd0, busy}, 32'd1);
    wait_out(4, 1'b0, "fwd0");
    accept("fwd0");

    // mixed bytes and inverse
    sb.push_back(32'hED16637C);
    drive_in(32'h53FF0001, 1'b0, 1'b0, "mix");
    wait_out(4, 1'b0, "mix");
    accept("mix");
    sb.push_back(32'h52525252);
    drive_in(32'h00000000, 1'b1, 1'b0, "inv0");
    wait_out(4, 1'b0, "inv0");
    accept("inv0");

    // RotWord
    sb.push_back(32'h8A84EB01);
    drive_in(32'h09CF4F3C, 1'b0, 1'b1, "rot");
    wait_out(4, 1'b0, "rot");
    accept("rot");

    // backpressure then simultaneous in/out transfer
    sb.push_back(32'h63636363);
    drive_in(32'h00000000, 1'b0, 1'b0, "bp");
    wait_out(4, 1'b0, "bp");
    repeat (6) begin
      @(posedge clk);
      #1;
      chk("bp_hold_word", out_word, 32'h63636363);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_word = 32'h63636363; in_inv = 1'b1; in_rot = 1'b0; in_valid = 1'b1;
    out_ready = 1'b1;
    #1 chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    sb.push_back(32'h00000000);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_out_valid", {31'd0, out_valid}, 32'd0);
    wait_out(4, 1'b0, "b2b");
    accept("b2b");

    // reset while in SUB at cnt==2
    drive_in(32'h12345678, 1'b0, 1'b0, "abort");
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1 chk("abort_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy_clr", {31'd0, busy}, 32'd0);
    chk("abort_out_word", out_word, 32'h0);
    rst = 1'b0;
    #1 chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    sb.push_back(32'h7C7C7C7C);
    drive_in(32'h01010101, 1'b0, 1'b0, "post");
    wait_out(4, 1'b0, "post");
    accept("post");

    // mode inputs toggling after capture must not matter
    sb.push_back(32'h8A84EB01);
    drive_in(32'h09CF4F3C, 1'b0, 1'b1, "iso1");
    wait_out(4, 1'b1, "iso1");
    accept("iso1");
    sb.push_back(32'h00015252);
    drive_in(32'h637C0000, 1'b1, 1'b0, "iso2");
    wait_out(4, 1'b1, "iso2");
    accept("iso2");
    sb.push_back(32'h01525200);
    drive_in(32'h637C0000, 1'b1, 1'b1, "iso3");
    wait_out(4, 1'b1, "iso3");
    accept("iso3");

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sbox_word_seq.md
# sbox_word_seq

Sequential word-level substitution stage built around the team's combinational combined S-box/inverse S-box core. It accepts 32-bit words with a valid/ready handshake and optionally rotates each word. It passes the word through a single core instance one byte per cycle, in forward or inverse direction, and returns the substituted word with a valid/ready handshake. It sits between the AES round/key-schedule datapath and the S-box core, so that one area-optimised core serves SubWord and SubBytes.

## Interface
- `NBYTES`, 4: bytes per word; legal range 2–16.
- `PIPE`, 0: when 1, adds a register between the byte mux and the S-box core input.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: stage can accept a word.
- `in_word` in 8*NBYTES: input word; byte k is `in_word[8k+7:8k]`.
- `in_inv` in 1: 0 selects the forward S-box; 1 selects the inverse S-box.
- `in_rot` in 1: 1 rotates the word left by 8 bits before substitution (RotWord).
- `out_valid` out 1: result word valid.
- `out_ready` in 1: downstream accepts the result.
- `out_word` out 8*NBYTES: substituted word.
- `busy` out 1: high in SUB or FLUSH.

## Operation
- Instantiates exactly one combinational S-box core. Core ports: 8-bit in, 8-bit out, direction select. The core direction select is driven from the registered `inv_q`.
- Handshakes:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
- States:
  - **IDLE**: `in_ready=1`.
  - **SUB**: one byte is substituted per cycle.
  - **FLUSH**: exists only when PIPE=1; it lasts one cycle and writes the last byte.
  - **DONE**: `out_valid=1`.
- Capture, on an input transfer:
  - `word_q` loads `in_word`, or `{in_word[8N-9:0], in_word[8N-1:8N-8]}` when `in_rot=1`.
  - `inv_q` loads `in_inv`.
  - `cnt` loads 0.
  - The FSM goes to SUB.
- SUB, PIPE=0:
  - Core input is `word_q[8*cnt+7:8*cnt]`.
  - The core result is written to `out_word` byte `cnt`, and `cnt` increments.
  - When `cnt==NBYTES-1`, the FSM goes to DONE.
- SUB, PIPE=1:
  - The byte is registered first (byte index registered alongside it), and the core result is written one cycle later.
  - After the last byte is issued, the FSM goes to FLUSH and then to DONE.
- DONE:
  - Holds `out_word` stable until the output transfer.
  - On transfer, goes to IDLE if no new input is present.
- Back-to-back operation:
  - `in_ready = (state==IDLE) || (state==DONE && out_ready)`.
  - A simultaneous output and input transfer in DONE captures the new word and goes directly to SUB, with no idle bubble.
- Bytes of `out_word` not yet written in SUB keep their previous values. They are not observable because `out_valid=0` there.
- `in_inv` and `in_rot` are sampled only at capture. Changes at other times have no effect.
- `cnt` is `$clog2(NBYTES)` bits wide. It is not wrap-dependent: the terminal compare is `cnt==NBYTES-1`.

## Timing
- Reset values:
  - state = IDLE, `cnt=0`, `out_word=0`, `out_valid=0`, `busy=0`.
  - `in_ready=0` while `rst=1`; `in_ready=1` in the first cycle after `rst` falls.
- Latency, from the capture edge to the first cycle with `out_valid=1`: NBYTES+PIPE cycles. With defaults this is 4 cycles.
- Throughput is 1 word per NBYTES+PIPE cycles when `out_ready` is held high.
- Reset mid-operation:
  - Asserting `rst` in any state aborts the word and returns to reset values on that edge.
  - No partial result is ever presented.
- Backpressure: `out_word` and `out_valid` do not change while `out_valid && !out_ready`.
- `in_ready` is combinational from state and `out_ready`. There is no combinational path from `in_valid` to any output.

## Test plan
1. Forward substitution: `in_word=0x00000000`, `in_inv=0` → after 4 cycles `out_valid=1`, `out_word=0x63636363`.
2. Mixed bytes: `in_word=0x53FF0001`, `in_inv=0` → `out_word=0xED16637C`. Repeat with `in_inv=1` on `0x00000000` → `out_word=0x52525252`.
3. Key-schedule RotWord: `in_word=0x09CF4F3C`, `in_rot=1`, `in_inv=0` → `out_word=0x8A84EB01`. With PIPE=1 the same value arrives after 5 cycles.
4. Backpressure and back-to-back:
   - Hold `out_ready=0` for 6 cycles after `out_valid` rises → `out_word` is stable and `in_ready=0`.
   - Then raise `out_ready` with `in_valid=1` on `0x63636363`, `in_inv=1` → both transfers occur on the same edge, and the next result `0x00000000` arrives 4 cycles later.
5. Reset mid-word: assert `rst` for 1 cycle in SUB at `cnt=2` → next cycle `out_valid=0`, `busy=0`, `out_word=0`, `in_ready=1`. A following word `0x01010101` yields `0x7C7C7C7C`.
6. Mode isolation: toggle `in_inv` and `in_rot` every cycle during SUB → the result is determined only by the captured values.
